tt_geared_bit_chain: RTL

Clocked, parametrised model of a row of Turing Tumble bit/geared-bit cells. Each position routes an arriving marble left or right according to its orientation, and then flips. Positions joined by the gear chain flip together. This block replaces the per-cell edge-triggered bit in the synchronous board fabric and adds:
- a gear linkage mask;
- programmable transit delay;
- board-setup load;
- collision detection;
- a marble counter.

---
 rtl/tt_pkg.sv | 20 ++
 rtl/tt_marble_delay.sv | 34 +++
 rtl/tt_geared_bit_chain.sv | 78 +++++++
 3 files changed

// File: rtl/tt_pkg.sv
// Shared types, limits and helpers for the geared bit-chain row.
package tt_pkg;

  typedef enum logic {
    ORIENT_RIGHT = 1'b0,
    ORIENT_LEFT  = 1'b1
  } tt_orient_e;

  localparam int TT_MAX_DELAY = 8;

  function automatic int unsigned tt_popcount(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/tt_marble_delay.sv
// DELAY-stage shift register carrying scheduled exit pulses; cleared by rst.
module tt_marble_delay #(
  parameter int W     = 8,
  parameter int DELAY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] pulse_i,
  output logic [W-1:0] pulse_o
);

  logic [W-1:0] stage_q [DELAY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q[0] <= '0;
    end else begin
      stage_q[0] <= pulse_i;
    end
  end

  for (genvar gi = 1; gi < DELAY; gi++) begin : g_stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stage_q[gi] <= '0;
      end else begin
        stage_q[gi] <= stage_q[gi-1];
      end
    end
  end

  assign pulse_o = stage_q[DELAY-1];

endmodule

// File: rtl/tt_geared_bit_chain.sv
// Row of Turing Tumble bit / geared-bit cells: routing, gear-chain toggling,
// board load, collision flag and marble counter.
module tt_geared_bit_chain
  import tt_pkg::*;
#(
  parameter int                N_BITS = 4,
  parameter logic [N_BITS-1:0] LINK   = {N_BITS{1'b1}},
  parameter logic [N_BITS-1:0] INIT   = {N_BITS{1'b0}},
  parameter int                DELAY  = 1,
  parameter int                CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BITS-1:0] i_left,
  input  logic [N_BITS-1:0] i_right,
  input  logic              ld_en,
  input  logic [N_BITS-1:0] ld_val,
  output logic [N_BITS-1:0] o_left,
  output logic [N_BITS-1:0] o_right,
  output logic [N_BITS-1:0] state,
  output logic              collision,
  output logic [CNT_W-1:0]  marble_cnt
);

  logic [N_BITS-1:0] m;
  logic [N_BITS-1:0] route_left;
  logic [N_BITS-1:0] route_right;
  logic [N_BITS-1:0] flip;
  logic [N_BITS-1:0] state_q, state_d;
  logic              coll_q, coll_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  int unsigned       linked_k;
  int unsigned       total_m;

  assign m = i_left | i_right;

  // Each marble is steered by the orientation held before this edge.
  for (genvar gi = 0; gi < N_BITS; gi++) begin : g_route
    assign route_left[gi]  = m[gi] & (state_q[gi] == ORIENT_LEFT);
    assign route_right[gi] = m[gi] & (state_q[gi] == ORIENT_RIGHT);
  end

  assign linked_k = tt_popcount(64'(m & LINK));
  assign total_m  = tt_popcount(64'(m));

  // Plain bits flip on their own marble; the gear chain flips as one on odd k.
  assign flip    = (m & ~LINK) | (LINK & {N_BITS{linked_k[0]}});
  assign state_d = ld_en ? ld_val : (state_q ^ flip);
  assign coll_d  = coll_q | (|(i_left & i_right)) | (linked_k >= 32'd2);
  assign cnt_d   = cnt_q + CNT_W'(total_m);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      coll_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      coll_q  <= coll_d;
      cnt_q   <= cnt_d;
    end
  end

  tt_marble_delay #(
    .W     (2 * N_BITS),
    .DELAY (DELAY)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .pulse_i ({route_left, route_right}),
    .pulse_o ({o_left, o_right})
  );

  assign state      = state_q;
  assign collision  = coll_q;
  assign marble_cnt = cnt_q;

endmodule
